// File: rtl/retire_trace_pipe.sv
// rtl/retire_trace_pipe.sv - retire trace shadow pipeline with registered trace FIFO (optional TRACE_DROP_CNT_EN drop counter)
module retire_trace_pipe #(
    parameter int STAGES     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int XLEN       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_valid,
    input  logic [XLEN-1:0]               fetch_pc,
    input  logic [XLEN-1:0]               fetch_instr,
    input  logic [4:0]                    fetch_rs,
    input  logic [4:0]                    fetch_rt,
    input  logic [4:0]                    fetch_rd,
    input  logic [1:0]                    fetch_type,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          retired,
    input  logic                          wb_we,
    input  logic [XLEN-1:0]               wb_data,
    output logic                          trc_valid,
    output logic [XLEN-1:0]               trc_pc,
    output logic [XLEN-1:0]               trc_instr,
    output logic [4:0]                    trc_rs,
    output logic [4:0]                    trc_rt,
    output logic [4:0]                    trc_rd,
    output logic [1:0]                    trc_type,
    output logic                          trc_we,
    output logic [XLEN-1:0]               trc_wdata,
    input  logic                          trc_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          proto_err
`ifdef TRACE_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 3 * XLEN + 15 + 2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Shadow stages: entry 0 captures fetch, entry STAGES-1 is the retire tail
    logic            st_valid [STAGES];
    logic [XLEN-1:0] st_pc    [STAGES];
    logic [XLEN-1:0] st_instr [STAGES];
    logic [4:0]      st_rs    [STAGES];
    logic [4:0]      st_rt    [STAGES];
    logic [4:0]      st_rd    [STAGES];
    logic [1:0]      st_type  [STAGES];

    // Trace FIFO storage and bookkeeping
    logic [RW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            tail_valid;
    logic            fifo_full;
    logic            do_pop;
    logic            push_req;
    logic            do_push;
    logic            drop;
    logic            perr_evt;
    logic [RW-1:0]   push_rec;
    logic [RW-1:0]   head_rec;

    // Retire decisions use the tail as it stands before this edge's shift
    always_comb begin
        tail_valid = st_valid[STAGES-1];
        fifo_full  = (count == FULL_CNT);
        do_pop     = trc_valid && trc_ready;
        push_req   = retired && !stall && tail_valid;
        do_push    = push_req && (!fifo_full || do_pop);
        drop       = push_req && fifo_full && !do_pop;
        perr_evt   = retired && (stall || !tail_valid);
        push_rec   = {st_pc[STAGES-1], st_instr[STAGES-1], st_rs[STAGES-1],
                      st_rt[STAGES-1], st_rd[STAGES-1], st_type[STAGES-1],
                      wb_we, wb_data};
    end

    // Stage valid bits: flush beats stall, stall freezes, otherwise shift toward the tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) st_valid[i] <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) st_valid[i] <= 1'b0;
        end else if (!stall) begin
            st_valid[0] <= fetch_valid;
            for (int i = 1; i < STAGES; i++) st_valid[i] <= st_valid[i-1];
        end
    end

    // Stage payload moves with the valid bits; contents are don't-care while invalid
    always_ff @(posedge clk) begin
        if (!stall && !flush) begin
            st_pc[0]    <= fetch_pc;
            st_instr[0] <= fetch_instr;
            st_rs[0]    <= fetch_rs;
            st_rt[0]    <= fetch_rt;
            st_rd[0]    <= fetch_rd;
            st_type[0]  <= fetch_type;
            for (int i = 1; i < STAGES; i++) begin
                st_pc[i]    <= st_pc[i-1];
                st_instr[i] <= st_instr[i-1];
                st_rs[i]    <= st_rs[i-1];
                st_rt[i]    <= st_rt[i-1];
                st_rd[i]    <= st_rd[i-1];
                st_type[i]  <= st_type[i-1];
            end
        end
    end

    // FIFO payload write; a dropped record never touches storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_rec;
    end

    // FIFO pointers, exact occupancy and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)     overflow  <= 1'b1;
            if (perr_evt) proto_err <= 1'b1;
        end
    end

`ifdef TRACE_DROP_CNT_EN
    // Saturating count of records dropped on a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    // Head presentation; zeroed when empty, which also covers reset since count clears asynchronously
    always_comb begin
        trc_valid  = (count != '0);
        fifo_count = count;
        head_rec   = trc_valid ? mem[rd_ptr] : '0;
        {trc_pc, trc_instr, trc_rs, trc_rt, trc_rd, trc_type, trc_we, trc_wdata} = head_rec;
    end

endmodule

// File: tb/tb_retire_trace_pipe.sv
// tb/tb_retire_trace_pipe.sv - self-checking bench for retire_trace_pipe
module tb_retire_trace_pipe;

    localparam int S = 4;
    localparam int D = 8;

    logic        clk_tb = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc, fetch_instr;
    logic [4:0]  fetch_rs, fetch_rt, fetch_rd;
    logic [1:0]  fetch_type;
    logic        stall, flush, retired, wb_we;
    logic [31:0] wb_data;
    logic        trc_valid;
    logic [31:0] trc_pc, trc_instr, trc_wdata;
    logic [4:0]  trc_rs, trc_rt, trc_rd;
    logic [1:0]  trc_type;
    logic        trc_we, trc_ready;
    logic [3:0]  fifo_count;
    logic        overflow, proto_err;
`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk_tb = ~clk_tb;

    retire_trace_pipe #(.STAGES(S), .FIFO_DEPTH(D), .XLEN(32)) dut (
        .clk(clk_tb), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .fetch_rs(fetch_rs), .fetch_rt(fetch_rt), .fetch_rd(fetch_rd), .fetch_type(fetch_type),
        .stall(stall), .flush(flush), .retired(retired), .wb_we(wb_we), .wb_data(wb_data),
        .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_instr(trc_instr),
        .trc_rs(trc_rs), .trc_rt(trc_rt), .trc_rd(trc_rd), .trc_type(trc_type),
        .trc_we(trc_we), .trc_wdata(trc_wdata), .trc_ready(trc_ready),
        .fifo_count(fifo_count), .overflow(overflow), .proto_err(proto_err)
`ifdef TRACE_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    typedef struct {
        bit          v;
        logic [31:0] pc, instr;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  ty;
    } slot_t;

    typedef struct {
        logic [31:0] pc, instr;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  ty;
        logic        we;
        logic [31:0] wd;
    } rec_t;

    // Reference: hist[k] is the fetch slot captured k non-stalled edges ago
    slot_t hist[$];
    rec_t  fq[$];
    bit    m_ovf, m_perr;
    int    m_drop;
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        slot_t e;
        e = '{default: '0};
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(e);
        fq.delete();
        m_ovf = 0; m_perr = 0; m_drop = 0;
    endtask

    task automatic check_all(input string tag);
        rec_t h;
        h = '{default: '0};
        if (fq.size() != 0) h = fq[0];
        chk({tag, ".count"},     64'(fifo_count), 64'(fq.size()));
        chk({tag, ".valid"},     64'(trc_valid), 64'(fq.size() != 0));
        chk({tag, ".pc"},        64'(trc_pc), 64'(h.pc));
        chk({tag, ".instr"},     64'(trc_instr), 64'(h.instr));
        chk({tag, ".regs"},      64'({trc_rs, trc_rt, trc_rd, trc_type}), 64'({h.rs, h.rt, h.rd, h.ty}));
        chk({tag, ".we"},        64'(trc_we), 64'(h.we));
        chk({tag, ".wdata"},     64'(trc_wdata), 64'(h.wd));
        chk({tag, ".overflow"},  64'(overflow), 64'(m_ovf));
        chk({tag, ".proto_err"}, 64'(proto_err), 64'(m_perr));
`ifdef TRACE_DROP_CNT_EN
        chk({tag, ".drop_cnt"},  64'(drop_cnt), 64'((m_drop > 65535) ? 65535 : m_drop));
`endif
    endtask

    // Applies the current inputs to the model, then advances one clock to the next falling edge
    task automatic tick();
        slot_t tl, cap;
        rec_t  r;
        bit    pop, push, full;
        tl   = hist[S-1];
        full = (fq.size() == D);
        pop  = (fq.size() != 0) && trc_ready;
        push = retired && !stall && tl.v;
        if (retired && !push) m_perr = 1;
        if (pop) fq.delete(0);
        if (push) begin
            if (full && !pop) begin
                m_ovf = 1;
                m_drop++;
            end else begin
                r = '{pc: tl.pc, instr: tl.instr, rs: tl.rs, rt: tl.rt, rd: tl.rd,
                      ty: tl.ty, we: wb_we, wd: wb_data};
                fq.push_back(r);
            end
        end
        if (flush) begin
            for (int i = 0; i < S; i++) hist[i].v = 0;
        end else if (!stall) begin
            cap = '{v: fetch_valid, pc: fetch_pc, instr: fetch_instr, rs: fetch_rs,
                    rt: fetch_rt, rd: fetch_rd, ty: fetch_type};
            hist.push_front(cap);
            hist.delete(S);
        end
        @(posedge clk_tb);
        @(negedge clk_tb);
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc);
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_instr = $urandom;
        fetch_rs    = 5'($urandom);
        fetch_rt    = 5'($urandom);
        fetch_rd    = 5'($urandom);
        fetch_type  = 2'($urandom);
    endtask

    // Asserted at a falling edge; outputs are checked before any clock edge arrives
    task automatic do_reset(input string tag);
        reset = 1'b1;
        model_reset();
        #1;
        chk({tag, ".async_valid"}, 64'(trc_valid), 64'd0);
        chk({tag, ".async_count"}, 64'(fifo_count), 64'd0);
        check_all(tag);
        @(negedge clk_tb);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_fetch(0, 0);
        stall = 0; flush = 0; retired = 0; wb_we = 0; wb_data = 0; trc_ready = 0;
        model_reset();
        repeat (2) @(negedge clk_tb);
        check_all("reset");
        reset = 1'b0;

        // Capture 0x100, reaches the tail after STAGES edges, retire with write-back
        set_fetch(1, 32'h100);
        tick();
        set_fetch(0, 0);
        repeat (S - 1) tick();
        chk("r030.pre_empty", 64'(trc_valid), 64'd0);
        retired = 1; wb_we = 1; wb_data = 32'hA;
        tick();
        retired = 0; wb_we = 0; wb_data = 0;
        chk("r030.pc", 64'(trc_pc), 64'h100);
        chk("r030.we", 64'(trc_we), 64'd1);
        chk("r030.wdata", 64'(trc_wdata), 64'hA);
        check_all("r030");
        trc_ready = 1;
        tick();
        trc_ready = 0;
        check_all("r030.pop");

        // Stall for 3 cycles mid-flight: tail reached after 4+3 edges
        set_fetch(1, 32'h200);
        tick();
        set_fetch(0, 0);
        tick();
        stall = 1;
        repeat (3) tick();
        stall = 0;
        repeat (S - 2) tick();
        retired = 1;
        tick();
        retired = 0;
        tick();
        chk("r031.pc", 64'(trc_pc), 64'h200);
        chk("r031.count", 64'(fifo_count), 64'd1);
        chk("r031.perr", 64'(proto_err), 64'd0);
        check_all("r031");
        trc_ready = 1;
        tick();
        trc_ready = 0;

        // Flush a full pipe, then retire: protocol error and nothing pushed
        for (int i = 0; i < S; i++) begin
            set_fetch(1, 32'h300 + 32'(4 * i));
            tick();
        end
        chk("r032.perr_before", 64'(proto_err), 64'd0);
        flush = 1;
        tick();
        flush = 0;
        set_fetch(0, 0);
        retired = 1;
        tick();
        retired = 0;
        chk("r032.perr", 64'(proto_err), 64'd1);
        chk("r032.count", 64'(fifo_count), 64'd0);
        check_all("r032");

        do_reset("rst1");

        // Nine retires into an 8-deep FIFO with no consumer
        for (int k = 0; k < S + 9; k++) begin
            set_fetch(1, 32'h1000 + 32'(4 * k));
            retired = (k >= S);
            wb_we = 1'($urandom);
            wb_data = $urandom;
            tick();
        end
        retired = 0;
        set_fetch(0, 0);
        chk("r033.count", 64'(fifo_count), 64'd8);
        chk("r033.overflow", 64'(overflow), 64'd1);
`ifdef TRACE_DROP_CNT_EN
        chk("r033.drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        check_all("r033.full");
        trc_ready = 1;
        for (int i = 0; i < D; i++) begin
            chk("r033.drain_pc", 64'(trc_pc), 64'(32'h1000 + 32'(4 * i)));
            tick();
            check_all("r033.drain");
        end
        trc_ready = 0;
        chk("r033.empty", 64'(fifo_count), 64'd0);

        do_reset("rst2");

        // Full FIFO with simultaneous push and pop, then reset mid-stream
        for (int k = 0; k < S + 8; k++) begin
            set_fetch(1, 32'h2000 + 32'(4 * k));
            retired = (k >= S);
            tick();
        end
        trc_ready = 1;
        tick();
        retired = 0;
        trc_ready = 0;
        set_fetch(0, 0);
        chk("r034.count", 64'(fifo_count), 64'd8);
        chk("r034.overflow", 64'(overflow), 64'd0);
        chk("r034.head", 64'(trc_pc), 64'h2004);
        check_all("r034.full");
        do_reset("r034.rst");

        // First record after reset
        set_fetch(1, 32'h3000);
        tick();
        set_fetch(0, 0);
        repeat (S - 1) tick();
        retired = 1;
        tick();
        retired = 0;
        chk("post_rst.pc", 64'(trc_pc), 64'h3000);
        check_all("post_rst");

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            set_fetch(1'($urandom), $urandom);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            retired   = ($urandom_range(0, 4) < 2);
            trc_ready = ($urandom_range(0, 2) == 0);
            wb_we     = 1'($urandom);
            wb_data   = $urandom;
            if ($urandom_range(0, 249) == 0) begin
                do_reset("rand.rst");
            end else begin
                tick();
                check_all("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
